// File: rtl/insn_boot_loader.sv
// Framed byte-stream loader: assembles little-endian words into instruction memory,
// verifies an XOR checksum, and releases the core from reset only after a clean load.
module insn_boot_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  core_reset_n,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_CNT_LO = 3'd0,
    S_CNT_HI = 3'd1,
    S_DATA   = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

  state_t      state;
  state_t      state_next;
  logic [7:0]  cnt_lo;
  logic [15:0] count;
  logic [1:0]  lane;
  logic [23:0] word_buf;
  logic [7:0]  csum;
  logic        accept;
  logic [15:0] rx_count;
  logic        last_word;

  assign rx_ready  = !reset && (state == S_CNT_LO || state == S_CNT_HI ||
                                state == S_DATA   || state == S_CHECK);
  assign accept    = rx_valid && rx_ready;
  assign rx_count  = {rx_data, cnt_lo};
  // words_loaded doubles as the index of the word currently being assembled
  assign last_word = (17'(words_loaded) + 17'd1) == {1'b0, count};

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_CNT_LO;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    case (state)
      S_CNT_LO: begin
        if (accept) state_next = S_CNT_HI;
        else        state_next = state;
      end
      S_CNT_HI: begin
        if (!accept)                         state_next = state;
        else if ({1'b0, rx_count} > MAX_WORDS) state_next = S_ERROR;
        else if (rx_count == 16'd0)          state_next = S_CHECK;
        else                                 state_next = S_DATA;
      end
      S_DATA: begin
        if (accept && lane == 2'd3 && last_word) state_next = S_CHECK;
        else                                     state_next = state;
      end
      S_CHECK: begin
        if (!accept)              state_next = state;
        else if (rx_data == csum) state_next = S_DONE;
        else                      state_next = S_ERROR;
      end
      S_DONE:  state_next = S_DONE;
      S_ERROR: state_next = S_ERROR;
      default: state_next = S_CNT_LO;
    endcase
  end

  // Datapath: count capture, word assembly, checksum and registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_lo       <= 8'd0;
      count        <= 16'd0;
      lane         <= 2'd0;
      word_buf     <= 24'd0;
      csum         <= 8'd0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= 32'd0;
      words_loaded <= '0;
      done         <= 1'b0;
      error        <= 1'b0;
      core_reset_n <= 1'b0;
    end else begin
      mem_we       <= 1'b0;
      done         <= (state_next == S_DONE);
      error        <= (state_next == S_ERROR);
      core_reset_n <= (state_next == S_DONE);
      case (state)
        S_CNT_LO: begin
          csum <= 8'd0;
          lane <= 2'd0;
          if (accept) cnt_lo <= rx_data;
        end
        S_CNT_HI: begin
          if (accept) count <= rx_count;
        end
        S_DATA: begin
          if (accept) begin
            csum <= csum ^ rx_data;
            if (lane == 2'd3) begin
              mem_we       <= 1'b1;
              mem_addr     <= words_loaded[ADDR_WIDTH-1:0];
              mem_wdata    <= {rx_data, word_buf};
              words_loaded <= words_loaded + 1'b1;
              lane         <= 2'd0;
            end else begin
              // shift in from the top so b0 ends up in the low byte after three lanes
              word_buf <= {rx_data, word_buf[23:8]};
              lane     <= lane + 2'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_insn_boot_loader.sv
// Self-checking bench for insn_boot_loader: directed frames plus randomized frames,
// checked against a frame-level reference model.
module tb_insn_boot_loader;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          core_reset_n;
  logic          done;
  logic          error;
  logic [AW:0]   words_loaded;

  insn_boot_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_reset_n(core_reset_n), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fails = 0;
  logic [7:0]  frame[$];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          we_double = 0;
  logic        we_prev = 1'b0;

  // Write monitor: records every memory write and flags strobes longer than one cycle
  always @(posedge clk) begin
    #1;
    if (mem_we) begin
      wr_addr_q.push_back(32'(mem_addr));
      wr_data_q.push_back(mem_wdata);
      if (we_prev) we_double++;
    end
    we_prev = mem_we;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rx_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("rx_ready_in_reset", 32'(rx_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_core_reset_n", 32'(core_reset_n), 32'd0);
    check("rst_words_loaded", 32'(words_loaded), 32'd0);
    check("rst_rx_ready", 32'(rx_ready), 32'd1);
  endtask

  // Presents one byte after `gap` idle cycles and waits (bounded) for its transfer
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_valid = 1'b1;
    rx_data = b;
    t = 0;
    while (!rx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready) check("rx_ready_timeout", 32'(rx_ready), 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Reference model: interpret the whole frame and compare against observed effects
  task automatic model_check(input string name);
    int          n;
    logic [7:0]  x;
    logic [31:0] w;
    bit          exp_done;
    bit          exp_err;
    int          exp_words;
    n = int'(frame[1]) * 256 + int'(frame[0]);
    if (n > (1 << AW)) begin
      exp_err = 1'b1; exp_done = 1'b0; exp_words = 0;
    end else begin
      x = 8'd0;
      for (int i = 0; i < 4 * n; i++) x = x ^ frame[2 + i];
      exp_done = (frame[2 + 4 * n] == x);
      exp_err = !exp_done;
      exp_words = n;
    end
    check({name, "_nwrites"}, 32'(wr_data_q.size()), 32'(exp_words));
    for (int i = 0; i < exp_words; i++) begin
      if (i < wr_data_q.size()) begin
        w = {frame[2 + 4 * i + 3], frame[2 + 4 * i + 2], frame[2 + 4 * i + 1], frame[2 + 4 * i]};
        check({name, "_addr"}, wr_addr_q[i], 32'(i));
        check({name, "_data"}, wr_data_q[i], w);
      end
    end
    check({name, "_words_loaded"}, 32'(words_loaded), 32'(exp_words));
    check({name, "_done"}, 32'(done), 32'(exp_done));
    check({name, "_error"}, 32'(error), 32'(exp_err));
    check({name, "_core_reset_n"}, 32'(core_reset_n), 32'(exp_done));
    check({name, "_rx_ready"}, 32'(rx_ready), 32'd0);
    check({name, "_we_pulse"}, 32'(we_double), 32'd0);
  endtask

  task automatic run_frame(input string name, input int gmin, input int gmax);
    do_reset();
    wr_addr_q.delete();
    wr_data_q.delete();
    we_double = 0;
    foreach (frame[i]) send_byte(frame[i], int'($urandom_range(gmax, gmin)));
    repeat (3) @(negedge clk);
    model_check(name);
  endtask

  task automatic load_test1();
    logic [7:0] t1[11] = '{8'h02, 8'h00, 8'h93, 8'h80, 8'h20, 8'h03,
                           8'h13, 8'hB1, 8'h40, 8'h01, 8'hD3};
    frame.delete();
    foreach (t1[i]) frame.push_back(t1[i]);
  endtask

  task automatic build_random(input int n, input bit good);
    logic [7:0] x;
    logic [7:0] b;
    frame.delete();
    frame.push_back(8'(n));
    frame.push_back(8'(n >> 8));
    x = 8'd0;
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      frame.push_back(b);
      x = x ^ b;
    end
    if (good) frame.push_back(x);
    else      frame.push_back(x ^ 8'($urandom_range(255, 1)));
  endtask

  initial begin
    load_test1();
    run_frame("t1", 0, 0);
    check("t1_word0", (wr_data_q.size() > 0) ? wr_data_q[0] : 32'hxxxxxxxx, 32'h03208093);
    check("t1_word1", (wr_data_q.size() > 1) ? wr_data_q[1] : 32'hxxxxxxxx, 32'h0140B113);

    load_test1();
    frame[10] = 8'hD2;
    run_frame("t2_badsum", 0, 0);

    frame = '{8'h00, 8'h00, 8'h00};
    run_frame("t3_empty_ok", 0, 0);
    frame = '{8'h00, 8'h00, 8'h5A};
    run_frame("t3_empty_bad", 0, 0);

    frame = '{8'h01, 8'h04};
    run_frame("t4_too_big", 0, 0);

    load_test1();
    run_frame("t5_gaps", 1, 3);

    // Reset after the 6th data byte: word 0 lands, partial word 1 is dropped
    load_test1();
    do_reset();
    wr_addr_q.delete();
    wr_data_q.delete();
    for (int i = 0; i < 8; i++) send_byte(frame[i], 0);
    repeat (3) @(negedge clk);
    check("t6_nwrites", 32'(wr_data_q.size()), 32'd1);
    check("t6_word0", (wr_data_q.size() > 0) ? wr_data_q[0] : 32'hxxxxxxxx, 32'h03208093);
    check("t6_words_loaded", 32'(words_loaded), 32'd1);
    run_frame("t6_resend", 0, 0);

    for (int k = 0; k < 6; k++) begin
      build_random(int'($urandom_range(8, 1)), bit'($urandom_range(1, 0)));
      run_frame("rand", 0, 2);
    end

    build_random(1 << AW, 1'b1);
    run_frame("full_mem", 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
